pwl_sequencer: RTL

//  Walks the piecewise-linear waveform table from an IParams.in bundle and issues one segment

---
 rtl/pwl_sequencer_if.sv | 13 +
 rtl/pwl_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pwl_sequencer_if.sv
// Parameter bundle carrying the piecewise-linear waveform table from the configurator.
interface IParams #(
    parameter int unsigned PARAM_SIZE = 32,
    parameter int unsigned POINTS     = 9
);
    logic [PARAM_SIZE-1:0] linea       [POINTS];
    logic [PARAM_SIZE-1:0] linet       [POINTS];
    logic [PARAM_SIZE-1:0] linet_int   [POINTS];
    logic [PARAM_SIZE-1:0] linenmb;
    logic [PARAM_SIZE-1:0] repeatcycle;

    modport in (input linea, input linet, input linet_int, input linenmb, input repeatcycle);
endinterface

// File: rtl/pwl_sequencer.sv
// Walks a latched PWL table and issues one segment descriptor per line over valid/ready,
// timing each segment and repeating the table a configurable number of passes.
module pwl_sequencer #(
    parameter int unsigned PARAM_SIZE = 32,
    parameter int unsigned POINTS     = 9
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    IParams.in                         prm,
    input  logic                       start,
    input  logic                       stop,
    output logic                       seg_valid,
    input  logic                       seg_ready,
    output logic [$clog2(POINTS)-1:0]  seg_idx,
    output logic [PARAM_SIZE-1:0]      seg_a0,
    output logic [PARAM_SIZE-1:0]      seg_a1,
    output logic [PARAM_SIZE-1:0]      seg_dur,
    output logic [PARAM_SIZE-1:0]      seg_int,
    output logic                       seg_last,
    output logic [PARAM_SIZE-1:0]      pass_cnt,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic                       cfg_err
);
    localparam int unsigned IW = $clog2(POINTS);
    localparam int unsigned PS = PARAM_SIZE;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;

    state_t          state;
    logic [PS-1:0]   linea_s [POINTS];
    logic [PS-1:0]   linet_s [POINTS];
    logic [PS-1:0]   lint_s  [POINTS];
    logic [PS-1:0]   rep_s;
    logic [IW-1:0]   nseg;
    logic [PS-1:0]   cnt;
    logic            stop_pend;

    logic            clamp_c;
    logic [IW-1:0]   nseg_c;
    logic            end_pass_c;
    logic            more_pass_c;
    logic            load_desc_c;
    logic [IW-1:0]   load_idx_c;
    logic [PS-1:0]   pass_inc_c;

    // Segment-count clamp, end-of-pass/repeat decisions and next descriptor index
    always_comb begin
        clamp_c     = (prm.linenmb == '0) || (prm.linenmb > PS'(POINTS - 1));
        nseg_c      = clamp_c ? IW'(POINTS - 1) : IW'(prm.linenmb);
        end_pass_c  = (seg_idx == IW'(nseg - IW'(1)));
        pass_inc_c  = pass_cnt + PS'(1);
        more_pass_c = (rep_s == '0) || (pass_inc_c < rep_s);
        load_desc_c = !stop && ((state == S_LOAD) ||
                                ((state == S_NEXT) && (!end_pass_c || more_pass_c)));
        load_idx_c  = ((state == S_NEXT) && !end_pass_c) ? IW'(seg_idx + IW'(1)) : '0;
    end

    // Snapshot of the whole parameter bundle when a run is started
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < int'(POINTS); k++) begin
                linea_s[k] <= '0;
                linet_s[k] <= '0;
                lint_s[k]  <= '0;
            end
            rep_s <= '0;
            nseg  <= '0;
        end else if ((state == S_IDLE) && start) begin
            for (int k = 0; k < int'(POINTS); k++) begin
                linea_s[k] <= prm.linea[k];
                linet_s[k] <= prm.linet[k];
                lint_s[k]  <= prm.linet_int[k];
            end
            rep_s <= prm.repeatcycle;
            nseg  <= nseg_c;
        end
    end

    // Descriptor fields, loaded on entry to ISSUE and frozen until the handshake
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            seg_idx  <= '0;
            seg_a0   <= '0;
            seg_a1   <= '0;
            seg_dur  <= '0;
            seg_int  <= '0;
            seg_last <= 1'b0;
        end else if (load_desc_c) begin
            seg_idx  <= load_idx_c;
            seg_a0   <= linea_s[load_idx_c];
            seg_a1   <= linea_s[IW'(load_idx_c + IW'(1))];
            seg_dur  <= (linet_s[load_idx_c] == '0) ? PS'(1) : linet_s[load_idx_c];
            seg_int  <= lint_s[load_idx_c];
            seg_last <= (load_idx_c == IW'(nseg - IW'(1)));
        end
    end

    // Sequencer FSM with registered handshake and status outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            seg_valid <= 1'b0;
            pass_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cfg_err   <= 1'b0;
            cnt       <= '0;
            stop_pend <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        busy      <= 1'b1;
                        pass_cnt  <= '0;
                        cfg_err   <= clamp_c;
                        stop_pend <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (stop) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else begin
                        state     <= S_ISSUE;
                        seg_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // a stop here must wait for the handshake; remember it
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (seg_ready) begin
                        seg_valid <= 1'b0;
                        cnt       <= PS'(1);
                        if (stop || stop_pend) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            aborted <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (stop) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (cnt >= seg_dur) begin
                        state <= S_NEXT;
                    end else begin
                        cnt <= cnt + PS'(1);
                    end
                end
                S_NEXT: begin
                    if (stop) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else begin
                        if (end_pass_c) begin
                            pass_cnt <= pass_inc_c;
                        end
                        if (load_desc_c) begin
                            state     <= S_ISSUE;
                            seg_valid <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
